mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//  Sits directly upstream of the 16-bit single-ported main memory and is its only master.
//  Arbitrates I-cache block fills, D-cache block fills and D-cache write-through stores.
//  Sequences each fill as BLOCK_WORDS back-to-back word reads.
//  Streams each returned word to the requesting cache with a word index and a write strobe.
// PARAMETERS
//  ADDR_WIDTH   16  byte-address width; matches the memory's addr port
//  BLOCK_WORDS  8   16-bit words per cache block; must be a power of 2
//                   OFF_BITS = $clog2(BLOCK_WORDS)+1 byte-offset bits
// PORTS
//  clk             in   1       single clock; all state updates on the rising edge
//  rst             in   1       asynchronous, active-high reset
//  icache_miss     in   1       I-cache fill request; level, held until icache_done
//  icache_addr     in   AW      I-cache miss byte address; only [AW-1:OFF_BITS] used
//  dcache_miss     in   1       D-cache fill request; level, held until dcache_done
//  dcache_addr     in   AW      D-cache miss byte address; only [AW-1:OFF_BITS] used
//  dcache_wr       in   1       store request; level, held until wr_done
//  dcache_wr_addr  in   AW      store byte address; bit 0 is forced to 0 toward memory
//  dcache_wr_data  in   16      store data
//  mem_addr        out  AW      to memory addr
//  mem_data_in     out  16      to memory data_in
//  mem_enable      out  1       to memory enable
//  mem_wr          out  1       to memory wr
//  mem_data_out    in   16      from memory data_out; combinational read
//  fill_data       out  16      returned word; equals mem_data_out during a fill
//  fill_idx        out  log2 BW word index within the block
//  fill_we_i       out  1       write fill_data into I-cache way at fill_idx
//  fill_we_d       out  1       write fill_data into D-cache way at fill_idx
//  icache_done     out  1       1-cycle pulse, coincides with the last I-fill word
//  dcache_done     out  1       1-cycle pulse, coincides with the last D-fill word
//  wr_done         out  1       1-cycle pulse, coincides with the memory write cycle
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, captured address/data regs=0.
//    With state=IDLE, every output above is 0.
//  States: IDLE, FILL_D, FILL_I, WRITE.
//  IDLE priority, highest first:
//    dcache_wr -> WRITE
//    dcache_miss -> FILL_D
//    icache_miss -> FILL_I
//    none -> stay in IDLE
//  On leaving IDLE: capture the block base (addr[AW-1:OFF_BITS]) or the store addr/data into regs.
//    Later changes on the inputs are ignored until the matching done pulse.
//  FILL_x, cycle k = cnt (0..BW-1):
//    mem_enable=1, mem_wr=0, mem_addr={base, cnt, 1'b0}
//    fill_we_x=1, fill_idx=cnt, fill_data=mem_data_out
//    cnt increments every cycle; no wait states.
//  When cnt==BW-1: assert x_done in that same cycle, clear cnt, next state is IDLE.
//  Fill latency: 1 cycle in IDLE + BW cycles in FILL.
//    The requester drops its miss at the edge ending the done cycle.
//    The next request can therefore start one cycle later.
//  WRITE lasts exactly 1 cycle:
//    mem_enable=1, mem_wr=1, mem_addr={wr_addr[AW-1:1], 1'b0}, mem_data_in=wr_data
//    wr_done=1; next state is IDLE.
//  A request arriving mid-operation waits; no preemption.
//    I and D misses raised in the same cycle: D fills first, then I.
//  Outside FILL/WRITE: mem_enable=0, mem_wr=0.
//    The memory therefore never sees a concurrent read and write.
//  Reset mid-fill: go straight to IDLE, cnt=0, no done pulse.
//    A still-held request restarts from word 0 after reset is released.
//  While rst=1: mem_enable=0 (the memory loads its image during rst).
//  cnt wraps only via the explicit clear at BW-1; the address never crosses the block base.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE, FILL_D, FILL_I, WRITE), BLOCK_WORDS, OFF_BITS.
//  Sub-module fill_word_counter: log2(BW)-bit counter with clear, enable and a last flag.
//  The FSM, capture regs and output muxing stay in mem_fill_arbiter.
// TESTING
//  1. dcache_miss=1, dcache_addr=0x1234, memory preloaded word[0x1230+2k]=0xA000+k
//     -> 8 cycles, mem_addr 0x1230..0x123E,
//     -> fill_we_d with fill_data 0xA000..0xA007, idx 0..7,
//     -> dcache_done pulses on idx 7 only.
//  2. icache_miss and dcache_miss both rise in the same cycle
//     -> D fill completes, one IDLE cycle, then I fill;
//     -> fill_we_i never overlaps fill_we_d.
//  3. dcache_wr=1, addr=0x0041, data=0xBEEF
//     -> one cycle with mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, wr_done=1;
//     -> a later fill of 0x0040 returns 0xBEEF at idx 0.
//  4. dcache_wr raised during the 3rd cycle of an I fill
//     -> I fill finishes unbroken; WRITE runs after one IDLE cycle.
//  5. rst pulsed at fill idx 4
//     -> outputs 0 immediately, no icache_done;
//     -> after release the fill restarts at idx 0 with the same base.
//  6. No requests for 20 cycles -> mem_enable=0, busy=0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the memory fill arbiter.
//   state_e     : arbiter FSM states
//   BLOCK_WORDS : 16-bit words per cache block (power of 2)
//   OFF_BITS    : byte-offset bits within a block
package mem_arb_pkg;

   localparam int BLOCK_WORDS = 8;
   localparam int OFF_BITS    = $clog2(BLOCK_WORDS) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL_D = 2'd1,
      FILL_I = 2'd2,
      WRITE  = 2'd3
   } state_e;

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for a block fill.
//   clk, rst : clock, async active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : advance by one
//   cnt_o    : current word index
//   last_o   : cnt_o is the final word of the block
module fill_word_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign last_o = &cnt_q;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Sole master of the 16-bit single-ported main memory. Arbitrates D-cache
// stores, D-cache block fills and I-cache block fills (in that priority) and
// streams each filled word back to the requesting cache.
//   icache_miss/addr, dcache_miss/addr : block fill requests (level)
//   dcache_wr/_wr_addr/_wr_data        : store request (level)
//   mem_*                              : memory interface, mem_data_out is a combinational read
//   fill_data/idx/we_i/we_d            : returned word toward the caches
//   icache_done, dcache_done, wr_done  : 1-cycle completion pulses
//   busy                               : an operation is in progress
module mem_fill_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           icache_miss,
   input  logic [ADDR_WIDTH-1:0]          icache_addr,
   input  logic                           dcache_miss,
   input  logic [ADDR_WIDTH-1:0]          dcache_addr,
   input  logic                           dcache_wr,
   input  logic [ADDR_WIDTH-1:0]          dcache_wr_addr,
   input  logic [15:0]                    dcache_wr_data,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic [15:0]                    mem_data_in,
   output logic                           mem_enable,
   output logic                           mem_wr,
   input  logic [15:0]                    mem_data_out,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
   output logic                           fill_we_i,
   output logic                           fill_we_d,
   output logic                           icache_done,
   output logic                           dcache_done,
   output logic                           wr_done,
   output logic                           busy
);

   localparam int IDX_W  = $clog2(BLOCK_WORDS);
   localparam int OFFB   = IDX_W + 1;
   localparam int BASE_W = ADDR_WIDTH - OFFB;

   state_e                  state_q, state_d;
   logic [BASE_W-1:0]       base_q, base_d;
   logic [ADDR_WIDTH-2:0]   waddr_q, waddr_d;
   logic [15:0]             wdata_q, wdata_d;
   logic [IDX_W-1:0]        cnt;
   logic                    cnt_last, cnt_clr, cnt_en;

   fill_word_counter #(.W(IDX_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      fill_data   = '0;
      fill_idx    = '0;
      fill_we_i   = 1'b0;
      fill_we_d   = 1'b0;
      icache_done = 1'b0;
      dcache_done = 1'b0;
      wr_done     = 1'b0;

      case (state_q)
         IDLE: begin
            // Request inputs are captured here and ignored until completion.
            if (dcache_wr) begin
               state_d = WRITE;
               waddr_d = dcache_wr_addr[ADDR_WIDTH-1:1];
               wdata_d = dcache_wr_data;
            end else if (dcache_miss) begin
               state_d = FILL_D;
               base_d  = dcache_addr[ADDR_WIDTH-1:OFFB];
            end else if (icache_miss) begin
               state_d = FILL_I;
               base_d  = icache_addr[ADDR_WIDTH-1:OFFB];
            end
         end
         FILL_D, FILL_I: begin
            mem_enable = 1'b1;
            mem_addr   = {base_q, cnt, 1'b0};
            fill_data  = mem_data_out;
            fill_idx   = cnt;
            fill_we_d  = (state_q == FILL_D);
            fill_we_i  = (state_q == FILL_I);
            cnt_en     = 1'b1;
            if (cnt_last) begin
               dcache_done = (state_q == FILL_D);
               icache_done = (state_q == FILL_I);
               cnt_clr     = 1'b1;
               state_d     = IDLE;
            end
         end
         WRITE: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = {waddr_q, 1'b0};
            mem_data_in = wdata_q;
            wr_done     = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: a bench-side memory, a
// transaction-level reference model compared every cycle, and directed
// scenarios with literal expectations.
module tb_mem_fill_arbiter;

   localparam int AW = 16;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          icache_miss, dcache_miss, dcache_wr;
   logic [AW-1:0] icache_addr, dcache_addr, dcache_wr_addr;
   logic [15:0]   dcache_wr_data;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_data_in, mem_data_out, fill_data;
   logic          mem_enable, mem_wr;
   logic [2:0]    fill_idx;
   logic          fill_we_i, fill_we_d, icache_done, dcache_done, wr_done, busy;

   logic [15:0]   mem [0:32767];
   int            errs = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   assign mem_data_out = mem[mem_addr[15:1]];

   mem_fill_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .icache_miss(icache_miss), .icache_addr(icache_addr),
      .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
      .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_data_out(mem_data_out),
      .fill_data(fill_data), .fill_idx(fill_idx), .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
      .icache_done(icache_done), .dcache_done(dcache_done), .wr_done(wr_done), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the transaction currently owning the memory.
   // kind 0 = none, 1 = D fill, 2 = I fill, 3 = store; k = word within fill.
   int          m_kind = 0;
   int          m_k    = 0;
   int          m_base = 0;
   int          m_wa   = 0;
   int          m_wd   = 0;

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      for (int k = 0; k < BW; k++) mem[(16'h1230 >> 1) + k] = 16'hA000 + 16'(k);
      forever begin
         @(negedge clk);
         if (rst) m_kind = 0;
         begin
            int ea;
            bit fill;
            fill = (m_kind == 1 || m_kind == 2);
            ea   = fill ? m_base * (BW * 2) + 2 * m_k : (m_kind == 3 ? (m_wa & 16'hFFFE) : 0);
            chk("busy",        32'(busy),        32'(m_kind != 0));
            chk("mem_enable",  32'(mem_enable),  32'(m_kind != 0));
            chk("mem_wr",      32'(mem_wr),      32'(m_kind == 3));
            chk("mem_addr",    32'(mem_addr),    32'(ea));
            chk("mem_data_in", 32'(mem_data_in), 32'(m_kind == 3 ? m_wd : 0));
            chk("fill_data",   32'(fill_data),   fill ? 32'(mem[ea / 2]) : 32'd0);
            chk("fill_idx",    32'(fill_idx),    32'(fill ? m_k : 0));
            chk("fill_we_d",   32'(fill_we_d),   32'(m_kind == 1));
            chk("fill_we_i",   32'(fill_we_i),   32'(m_kind == 2));
            chk("dcache_done", 32'(dcache_done), 32'(m_kind == 1 && m_k == BW - 1));
            chk("icache_done", 32'(icache_done), 32'(m_kind == 2 && m_k == BW - 1));
            chk("wr_done",     32'(wr_done),     32'(m_kind == 3));
            if (fill_we_i && fill_we_d) chk("we_overlap", 32'd1, 32'd0);
            // The store lands in memory at the end of its cycle.
            if (mem_enable && mem_wr) mem[mem_addr[15:1]] = mem_data_in;
         end
         @(posedge clk);
         if (rst) m_kind = 0;
         else if (m_kind == 0) begin
            m_k = 0;
            if (dcache_wr) begin
               m_kind = 3; m_wa = int'(dcache_wr_addr); m_wd = int'(dcache_wr_data);
            end else if (dcache_miss) begin
               m_kind = 1; m_base = int'(dcache_addr) / (BW * 2);
            end else if (icache_miss) begin
               m_kind = 2; m_base = int'(icache_addr) / (BW * 2);
            end
         end else if (m_kind == 3) m_kind = 0;
         else begin
            m_k++;
            if (m_k == BW) begin m_kind = 0; m_k = 0; end
         end
      end
   end

   // One clock; the requesters drop a request at the edge ending its done cycle.
   task automatic step();
      logic dd, id, wd;
      @(negedge clk);
      dd = dcache_done; id = icache_done; wd = wr_done;
      @(posedge clk);
      #1;
      if (dd) dcache_miss = 1'b0;
      if (id) icache_miss = 1'b0;
      if (wd) dcache_wr   = 1'b0;
   endtask

   // mask: {wr, dmiss, imiss}
   task automatic wait_req(input logic [2:0] mask, input int budget);
      int n = 0;
      while ((({dcache_wr, dcache_miss, icache_miss} & mask) != 3'b000) && n < budget) begin
         step();
         n++;
      end
      chk("timeout", 32'(n >= budget), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      icache_miss = 0; dcache_miss = 0; dcache_wr = 0;
      icache_addr = '0; dcache_addr = '0; dcache_wr_addr = '0; dcache_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_en",   32'(mem_enable), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      rst = 1'b0;
      step();

      // 1: D fill of 0x1234
      dcache_miss = 1; dcache_addr = 16'h1234;
      step();
      for (int k = 0; k < BW; k++) begin
         chk("t1_addr", 32'(mem_addr),    32'h1230 + 32'(2 * k));
         chk("t1_data", 32'(fill_data),   32'hA000 + 32'(k));
         chk("t1_idx",  32'(fill_idx),    32'(k));
         chk("t1_we",   32'(fill_we_d),   1);
         chk("t1_done", 32'(dcache_done), 32'(k == BW - 1));
         step();
      end
      chk("t1_idle", 32'(busy), 0);

      // 2: simultaneous D and I misses
      dcache_miss = 1; dcache_addr = 16'h0800;
      icache_miss = 1; icache_addr = 16'h0900;
      step();
      chk("t2_dfirst", 32'(fill_we_d), 1);
      wait_req(3'b010, 20);
      chk("t2_gap", 32'(busy), 0);
      step();
      chk("t2_ifill", 32'(fill_we_i), 1);
      chk("t2_iaddr", 32'(mem_addr), 32'h0900);
      wait_req(3'b001, 20);

      // 3: store, then read it back via a fill
      dcache_wr = 1; dcache_wr_addr = 16'h0041; dcache_wr_data = 16'hBEEF;
      step();
      chk("t3_wr",   32'(mem_wr), 1);
      chk("t3_addr", 32'(mem_addr), 32'h0040);
      chk("t3_data", 32'(mem_data_in), 32'hBEEF);
      chk("t3_done", 32'(wr_done), 1);
      wait_req(3'b100, 5);
      step();
      dcache_miss = 1; dcache_addr = 16'h0040;
      step();
      chk("t3_rd",    32'(fill_data), 32'hBEEF);
      chk("t3_rdidx", 32'(fill_idx), 0);
      wait_req(3'b010, 20);

      // 4: store raised during the 3rd word of an I fill
      icache_miss = 1; icache_addr = 16'h2000;
      step(); step(); step();
      chk("t4_idx2", 32'(fill_idx), 2);
      dcache_wr = 1; dcache_wr_addr = 16'h0100; dcache_wr_data = 16'h1111;
      wait_req(3'b001, 20);
      chk("t4_gap", 32'(busy), 0);
      step();
      chk("t4_wr",   32'(mem_wr), 1);
      chk("t4_addr", 32'(mem_addr), 32'h0100);
      wait_req(3'b100, 5);

      // 5: reset in the middle of an I fill
      icache_miss = 1; icache_addr = 16'h3456;
      step();
      repeat (4) step();
      chk("t5_idx4", 32'(fill_idx), 4);
      rst = 1;
      #1;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_en",   32'(mem_enable), 0);
      chk("t5_we",   32'(fill_we_i), 0);
      chk("t5_done", 32'(icache_done), 0);
      step();
      rst = 0;
      step();
      chk("t5_restart", 32'(fill_idx), 0);
      chk("t5_base",    32'(mem_addr), 32'h3450);
      wait_req(3'b001, 20);

      // 6: quiet period
      for (int i = 0; i < 20; i++) begin
         step();
         chk("t6_busy", 32'(busy), 0);
         chk("t6_en",   32'(mem_enable), 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
